// File: rtl/aludec_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aludec_seq
//  Description : Registered ALU decoder for the datapath_plus MIPS core.
//                Decodes the main-decoder ALU op class plus R-type funct into
//                an ALU control code, one pipeline stage deep. It has a
//                valid/ready handshake on both sides and holds off new decodes
//                while the mult/div unit is running.
//  Ports       : clk         - rising-edge clock
//                reset       - asynchronous, active-low reset
//                in_valid    - aluop/funct valid
//                in_ready    - block can accept this cycle
//                aluop       - main-decoder ALU op class (3 bits)
//                funct       - instr[5:0]
//                out_valid   - alucontrol/flags valid
//                out_ready   - consumer takes output this cycle
//                alucontrol  - ALU operation code (ACW bits, zero-extended)
//                md_unsigned - MULTU/DIVU decoded
//                illegal     - unsupported aluop/funct
//                md_busy     - mult/div in progress
//                md_done     - one-cycle pulse when md_busy falls
//  Revision    : 1.0 - initial release
// ============================================================================
module aludec_seq #(
  parameter int ACW     = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter bit EXT_EN  = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     aluop,
  input  logic [5:0]     funct,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [ACW-1:0] alucontrol,
  output logic           md_unsigned,
  output logic           illegal,
  output logic           md_busy,
  output logic           md_done
);

  localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

  localparam logic [3:0] c_AND  = 4'b0000;
  localparam logic [3:0] c_OR   = 4'b0001;
  localparam logic [3:0] c_ADD  = 4'b0010;
  localparam logic [3:0] c_BNE  = 4'b0011;
  localparam logic [3:0] c_BEQ  = 4'b0100;
  localparam logic [3:0] c_SUB  = 4'b0110;
  localparam logic [3:0] c_SLT  = 4'b0111;
  localparam logic [3:0] c_XOR  = 4'b1000;
  localparam logic [3:0] c_NOR  = 4'b1001;
  localparam logic [3:0] c_SLTU = 4'b1010;
  localparam logic [3:0] c_SLL  = 4'b1011;
  localparam logic [3:0] c_SRL  = 4'b1100;
  localparam logic [3:0] c_SRA  = 4'b1101;
  localparam logic [3:0] c_MULT = 4'b1110;
  localparam logic [3:0] c_DIV  = 4'b1111;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MD_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_md_done;
  logic               w_md_done_nxt;

  logic               r_out_valid;
  logic [ACW-1:0]     r_alucontrol;
  logic               r_md_unsigned;
  logic               r_illegal;

  logic [3:0]         w_code;
  logic               w_uns;
  logic               w_ill;
  logic               w_ext;
  logic               w_mul;
  logic               w_div;
  logic               w_accept;
  logic               w_start_md;

  // --------------------------------------------------------------------------
  // Combinational decode. Extended functs are decoded first and then
  // overridden to an illegal ADD when the extended set is disabled.
  // --------------------------------------------------------------------------
  always_comb begin
    w_code = c_ADD;
    w_uns  = 1'b0;
    w_ill  = 1'b0;
    w_ext  = 1'b0;
    w_mul  = 1'b0;
    w_div  = 1'b0;
    case (aluop)
      3'b000: w_code = c_ADD;
      3'b001: w_code = c_BEQ;
      3'b011: w_code = c_BNE;
      3'b100: w_code = c_OR;
      3'b101: w_code = c_AND;
      3'b111: w_code = c_SLT;
      3'b010: begin
        case (funct)
          6'b100000, 6'b100001: w_code = c_ADD;
          6'b100010, 6'b100011: w_code = c_SUB;
          6'b100100:            w_code = c_AND;
          6'b100101:            w_code = c_OR;
          6'b101010:            w_code = c_SLT;
          6'b100110: begin w_code = c_XOR;  w_ext = 1'b1; end
          6'b100111: begin w_code = c_NOR;  w_ext = 1'b1; end
          6'b101011: begin w_code = c_SLTU; w_ext = 1'b1; end
          6'b000000: begin w_code = c_SLL;  w_ext = 1'b1; end
          6'b000010: begin w_code = c_SRL;  w_ext = 1'b1; end
          6'b000011: begin w_code = c_SRA;  w_ext = 1'b1; end
          6'b011000, 6'b011001: begin
            w_code = c_MULT;
            w_ext  = 1'b1;
            w_mul  = 1'b1;
            w_uns  = funct[0];
          end
          6'b011010, 6'b011011: begin
            w_code = c_DIV;
            w_ext  = 1'b1;
            w_div  = 1'b1;
            w_uns  = funct[0];
          end
          default: w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase

    if (w_ext && !EXT_EN) begin
      w_code = c_ADD;
      w_uns  = 1'b0;
      w_ill  = 1'b1;
      w_mul  = 1'b0;
      w_div  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake. Accept only when the mult/div unit is idle and the output
  // register is empty or being drained this same edge.
  // --------------------------------------------------------------------------
  assign md_busy    = (r_state == S_MD_BUSY);
  assign in_ready   = !md_busy && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_start_md = w_accept && (w_mul || w_div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid   <= 1'b0;
      r_alucontrol  <= '0;
      r_md_unsigned <= 1'b0;
      r_illegal     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_alucontrol  <= ACW'(w_code);
      r_md_unsigned <= w_uns;
      r_illegal     <= w_ill;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign alucontrol  = r_alucontrol;
  assign md_unsigned = r_md_unsigned;
  assign illegal     = r_illegal;

  // --------------------------------------------------------------------------
  // Mult/div busy FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_md_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_md_done <= w_md_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Mult/div busy FSM: next state. The counter holds the number of busy
  // cycles still to run, so md_busy stays high for exactly the latency.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_md_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_md) begin
          w_state_nxt = S_MD_BUSY;
          w_cnt_nxt   = w_mul ? c_CNT_W'(MUL_LAT) : c_CNT_W'(DIV_LAT);
        end
      end
      S_MD_BUSY: begin
        w_cnt_nxt = r_cnt - c_CNT_W'(1);
        if (r_cnt == c_CNT_W'(1)) begin
          w_state_nxt   = S_IDLE;
          w_md_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign md_done = r_md_done;

endmodule
`default_nettype wire
